// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one-at-a-time instruction memory requests and buffers {pc, instr} in a 2-entry queue.
// Optional macro FETCH_BYPASS_EN: a response arriving at an empty queue is presented on the outputs in the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    typedef enum logic {
        FETCH,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] discard_pc;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        head;
    logic [1:0]  count;

    logic accept;
    logic bypass_take;
    logic push;
    logic pop;
    logic tail;

    // NOTE: imem_req is gated by reset combinationally so no request is ever shown while reset is held.
    assign imem_req  = reset && ((state == DISCARD) || (count != 2'd2));
    assign imem_addr = (state == DISCARD) ? discard_pc : fetch_pc;
    assign accept    = (state == FETCH) && imem_req && imem_ready;
    assign pop       = (count != 2'd0) && instr_ready;
    assign tail      = head ^ count[0];

`ifdef FETCH_BYPASS_EN
    logic bypass_show;
    assign bypass_show = accept && !redirect && (count == 2'd0);
    assign bypass_take = bypass_show && instr_ready;
    assign instr_valid = (count != 2'd0) || bypass_show;
    assign instr       = bypass_show ? imem_data : q_instr[head];
    assign instr_pc    = bypass_show ? fetch_pc : q_pc[head];
`else
    assign bypass_take = 1'b0;
    assign instr_valid = (count != 2'd0);
    assign instr       = q_instr[head];
    assign instr_pc    = q_pc[head];
`endif

    // A bypassed response that is consumed immediately never occupies a queue slot.
    assign push = accept && !redirect && !bypass_take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            discard_pc <= RESET_PC;
            count      <= 2'd0;
            head       <= 1'b0;
            // NOTE: the queue storage is reset too, because instr/instr_pc must read zero out of reset.
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else if (redirect) begin
            count    <= 2'd0;
            fetch_pc <= redirect_pc;
            if ((state == FETCH) && imem_req && !imem_ready) begin
                state      <= DISCARD;
                discard_pc <= fetch_pc;
            end else if ((state == DISCARD) && imem_ready) begin
                state <= FETCH;
            end
        end else begin
            if ((state == DISCARD) && imem_ready) begin
                state <= FETCH;
            end
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) begin
                q_pc[tail]    <= fetch_pc;
                q_instr[tail] <= imem_data;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic; a monitor checks every consumed instruction against a PC-stream scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RST   = 32'h10;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int n_checks = 0;
    int n_errors = 0;
    int pops     = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;

    fetch_unit #(.RESET_PC(RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    // Instruction memory: content is a fixed function of the word address.
    assign imem_data = imem_addr ^ MAGIC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // The program is a straight-line stream from the last reset/redirect target.
    function automatic void top_up();
        while (exp_q.size() < 4) begin
            exp_q.push_back({gen_pc, gen_pc ^ MAGIC});
            gen_pc = gen_pc + 32'd1;
        end
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
        top_up();
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            restart(RST);
            prev_hold = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                check("mon_pc", instr_pc, e.pc);
                check("mon_instr", instr, e.data);
                pops++;
                top_up();
            end
            if (redirect) restart(redirect_pc);
            if (prev_hold) check("addr_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
            prev_hold = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time, errors %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_req", imem_req, 0);

        // Streaming from RESET_PC, one instruction per cycle.
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("run_req", imem_req, 1);
            check("run_addr", imem_addr, RST + 32'(k));
            if (k >= LAT) begin
                check("run_valid", instr_valid, 1);
                check("run_pc", instr_pc, RST + 32'(k - LAT));
            end else begin
                check("run_first_valid", instr_valid, 0);
            end
            next_cycle();
        end

        // Memory stalls at 0x14; redirect to 0x40 during the second wait cycle.
        for (int k = 0; k < 4; k++) begin
            redirect    = (k == 1);
            redirect_pc = 32'h40;
            imem_ready  = (k == 3);
            @(negedge clk);
            check("disc_req", imem_req, 1);
            check("disc_addr", imem_addr, 32'h14);
            if (k == 2) check("disc_valid", instr_valid, 0);
            next_cycle();
        end
        redirect   = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h40);
        begin
            bit found = 1'b0;
            for (int t = 0; t < 8; t++) begin
                if (instr_valid) begin
                    found = 1'b1;
                    break;
                end
                next_cycle();
                @(negedge clk);
            end
            check("redir_found", found, 1);
            check("redir_first_pc", instr_pc, 32'h40);
        end

        // Consumer stalls: queue fills and the request drops.
        next_cycle();
        instr_ready = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("full_req", imem_req, 0);
        check("full_valid", instr_valid, 1);
        next_cycle();
        instr_ready = 1'b1;
        @(negedge clk);
        check("pop_no_req", imem_req, 0);
        next_cycle();
        @(negedge clk);
        check("refill_req", imem_req, 1);

        // Redirect together with a response and a pop.
        repeat (3) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        check("flush_req", imem_req, 1);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("flush_addr", imem_addr, 32'h80);
        check("flush_valid", instr_valid, LAT == 0);
        if (LAT != 0) begin
            next_cycle();
            @(negedge clk);
        end
        check("flush_first_valid", instr_valid, 1);
        check("flush_first_pc", instr_pc, 32'h80);

        // PC wrap.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_last", imem_addr, 32'hFFFF_FFFF);
        next_cycle();
        @(negedge clk);
        check("wrap_zero", imem_addr, 32'h0);

        // One-cycle reset mid-stream.
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req", imem_req, 0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_addr", imem_addr, RST);
        check("mid_rst_req1", imem_req, 1);
        check("mid_rst_valid", instr_valid, LAT == 0);
`ifdef FETCH_BYPASS_EN
        check("mid_rst_bypass_pc", instr_pc, RST);
        check("mid_rst_bypass_instr", instr, RST ^ MAGIC);
`else
        check("mid_rst_pc", instr_pc, 0);
        check("mid_rst_instr", instr, 0);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            imem_ready  = ($urandom_range(0, 9) < 7);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            reset       = ($urandom_range(0, 299) != 0);
        end
        next_cycle();
        reset       = 1'b1;
        redirect    = 1'b0;
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        repeat (10) next_cycle();
        @(negedge clk);
        check("progress", pops > 500, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
